mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller.sv | 157 +++++++++++++++
 tb/tb_mc_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multicycle controller FSM for a shared-memory MIPS-style datapath.
// Moore outputs from the current state; alucontrol also follows funct and pcen follows zero in BEQEX.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic       pcen,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] immtype,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        IMMWB   = 4'd10,
        JEX     = 4'd11,
        ORIEX   = 4'd12
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    state_t     out_state;
    logic [2:0] funct_alu;

    always_ff @(posedge clk) begin
        if (!reset) state_reg <= FETCH;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = FETCH;
        case (state_reg)
            FETCH:   state_next = DECODE;
            DECODE: begin
                case (op)
                    6'b100011, 6'b101011: state_next = MEMADR;
                    6'b000000:            state_next = EXECUTE;
                    6'b000100:            state_next = BEQEX;
                    6'b001000:            state_next = ADDIEX;
                    6'b001101:            state_next = ORIEX;
                    6'b000010:            state_next = JEX;
                    default:              state_next = FETCH;
                endcase
            end
            MEMADR:  state_next = (op == 6'b100011) ? MEMRD : MEMWR;
            MEMRD:   state_next = MEMWB;
            EXECUTE: state_next = ALUWB;
            ADDIEX:  state_next = IMMWB;
            ORIEX:   state_next = IMMWB;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        funct_alu = 3'b010;
        case (funct)
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            default:   funct_alu = 3'b010;
        endcase
    end

    // Holding reset low presents the FETCH control word even before the first edge.
    assign out_state = reset ? state_reg : FETCH;
    assign state     = state_reg;

    always_comb begin
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        pcen       = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        immtype    = 2'b00;
        alucontrol = 3'b000;
        case (out_state)
            FETCH: begin
                irwrite    = 1'b1;
                alusrcb    = 2'b01;
                pcen       = 1'b1;
                alucontrol = 3'b010;
            end
            DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = 3'b010;
            end
            MEMADR, ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = 3'b010;
            end
            MEMRD: iord = 1'b1;
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            IMMWB: regwrite = 1'b1;
            EXECUTE: begin
                alusrca    = 1'b1;
                alucontrol = funct_alu;
            end
            BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                pcen       = zero;
            end
            ORIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                immtype    = 2'b01;
                alucontrol = 3'b001;
            end
            JEX: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed instruction table, reset corner cases, and
// random instruction streams checked against an instruction-level reference model.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
    logic [1:0] alusrcb, pcsrc, immtype;
    logic [2:0] alucontrol;
    logic [3:0] state;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .pcen(pcen),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .immtype(immtype),
        .alucontrol(alucontrol), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic       pcen;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] immtype;
        logic [2:0] alucontrol;
    } ctrl_t;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        int          n;
        logic [23:0] seq;   // expected states, first in the low nibble
    } vec_t;

    ctrl_t dut_ctrl;
    assign dut_ctrl = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen,
                       alusrcb, pcsrc, immtype, alucontrol};

    ctrl_t base [16];
    vec_t  tbl  [14];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] alu_for(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic ctrl_t ref_ctrl(input logic [3:0] st, input logic [5:0] f, input logic z);
        ctrl_t c;
        c = base[st];
        if (st == 4'd6) c.alucontrol = alu_for(f);
        if (st == 4'd8) c.pcen = z;
        return c;
    endfunction

    // Instruction-level model: the list of states an opcode walks through.
    function automatic void op_seq(input logic [5:0] o, output logic [23:0] s, output int n);
        case (o)
            6'b100011: begin s = 24'h043210; n = 5; end
            6'b101011: begin s = 24'h005210; n = 4; end
            6'b000000: begin s = 24'h007610; n = 4; end
            6'b000100: begin s = 24'h000810; n = 3; end
            6'b001000: begin s = 24'h00A910; n = 4; end
            6'b001101: begin s = 24'h00AC10; n = 4; end
            6'b000010: begin s = 24'h000B10; n = 3; end
            default:   begin s = 24'h000010; n = 2; end
        endcase
    endfunction

    task automatic run_vec(input vec_t v);
        logic [3:0] st;
        op = v.op; funct = v.funct; zero = v.zero;
        #1;
        for (int i = 0; i < v.n; i++) begin
            st = v.seq[4*i +: 4];
            chk({v.name, "_state"}, 32'(state), 32'(st));
            chk({v.name, "_ctrl"}, 32'(dut_ctrl), 32'(ref_ctrl(st, v.funct, v.zero)));
            tick();
        end
        chk({v.name, "_end"}, 32'(state), 32'd0);
        $display("vec %-8s op=%b funct=%b zero=%0d states=%0d", v.name, v.op, v.funct, v.zero, v.n);
    endtask

    initial begin
        ctrl_t c;
        logic [23:0] s;
        int n;
        int abort_at;
        logic [3:0] st;

        for (int i = 0; i < 16; i++) base[i] = '0;
        c = '0; c.irwrite = 1; c.alusrcb = 2'b01; c.pcen = 1; c.alucontrol = 3'b010; base[0] = c;
        c = '0; c.alusrcb = 2'b11; c.alucontrol = 3'b010; base[1] = c;
        c = '0; c.alusrca = 1; c.alusrcb = 2'b10; c.alucontrol = 3'b010; base[2] = c; base[9] = c;
        c = '0; c.iord = 1; base[3] = c;
        c = '0; c.memtoreg = 1; c.regwrite = 1; base[4] = c;
        c = '0; c.iord = 1; c.memwrite = 1; base[5] = c;
        c = '0; c.alusrca = 1; base[6] = c;
        c = '0; c.regdst = 1; c.regwrite = 1; base[7] = c;
        c = '0; c.alusrca = 1; c.alucontrol = 3'b110; c.pcsrc = 2'b01; base[8] = c;
        c = '0; c.regwrite = 1; base[10] = c;
        c = '0; c.pcsrc = 2'b10; c.pcen = 1; base[11] = c;
        c = '0; c.alusrca = 1; c.alusrcb = 2'b10; c.immtype = 2'b01; c.alucontrol = 3'b001; base[12] = c;

        tbl[0]  = '{"lw",     6'b100011, 6'b000000, 1'b0, 5, 24'h043210};
        tbl[1]  = '{"sub",    6'b000000, 6'b100010, 1'b0, 4, 24'h007610};
        tbl[2]  = '{"beq_z1", 6'b000100, 6'b000000, 1'b1, 3, 24'h000810};
        tbl[3]  = '{"beq_z0", 6'b000100, 6'b000000, 1'b0, 3, 24'h000810};
        tbl[4]  = '{"ori",    6'b001101, 6'b000000, 1'b0, 4, 24'h00AC10};
        tbl[5]  = '{"undef",  6'b111111, 6'b000000, 1'b0, 2, 24'h000010};
        tbl[6]  = '{"sw",     6'b101011, 6'b000000, 1'b0, 4, 24'h005210};
        tbl[7]  = '{"addi",   6'b001000, 6'b000000, 1'b0, 4, 24'h00A910};
        tbl[8]  = '{"j",      6'b000010, 6'b000000, 1'b0, 3, 24'h000B10};
        tbl[9]  = '{"add",    6'b000000, 6'b100000, 1'b0, 4, 24'h007610};
        tbl[10] = '{"and",    6'b000000, 6'b100100, 1'b1, 4, 24'h007610};
        tbl[11] = '{"or",     6'b000000, 6'b100101, 1'b0, 4, 24'h007610};
        tbl[12] = '{"slt",    6'b000000, 6'b101010, 1'b0, 4, 24'h007610};
        tbl[13] = '{"rbad",   6'b000000, 6'b110011, 1'b1, 4, 24'h007610};

        // Reset: FETCH word must appear while reset is low, before and after edges.
        reset = 1'b0; op = 6'b100011; funct = 6'b0; zero = 1'b0;
        #1;
        chk("rst_comb_ctrl", 32'(dut_ctrl), 32'(base[0]));
        tick(); tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ctrl", 32'(dut_ctrl), 32'(base[0]));
        reset = 1'b1;

        for (int i = 0; i < 14; i++) run_vec(tbl[i]);

        // Reset asserted mid-instruction in MEMWR.
        op = 6'b101011; #1;
        tick(); tick(); tick();
        chk("memwr_state", 32'(state), 32'd5);
        chk("memwr_memwrite", 32'(memwrite), 32'd1);
        reset = 1'b0; #1;
        chk("memwr_rst_comb", 32'(dut_ctrl), 32'(base[0]));
        tick();
        chk("memwr_rst_state", 32'(state), 32'd0);
        chk("memwr_rst_memwrite", 32'(memwrite), 32'd0);
        chk("memwr_rst_irwrite", 32'(irwrite), 32'd1);
        reset = 1'b1;
        tick();
        chk("memwr_release", 32'(state), 32'd1);
        $display("seq reset_in_memwr done");

        // A reset pulse between edges must have no effect.
        #1 reset = 1'b0;
        #1 reset = 1'b1;
        tick();
        chk("glitch_state", 32'(state), 32'd2);
        tick(); tick();
        chk("glitch_end", 32'(state), 32'd0);
        $display("seq reset_glitch done");

        // Random instruction stream with occasional mid-instruction resets.
        for (int k = 0; k < 200; k++) begin
            case ($urandom_range(0, 9))
                0: op = 6'b100011;
                1: op = 6'b101011;
                2, 3: op = 6'b000000;
                4: op = 6'b000100;
                5: op = 6'b001000;
                6: op = 6'b001101;
                7: op = 6'b000010;
                default: op = 6'($urandom);
            endcase
            case ($urandom_range(0, 6))
                0: funct = 6'b100000;
                1: funct = 6'b100010;
                2: funct = 6'b100100;
                3: funct = 6'b100101;
                4: funct = 6'b101010;
                default: funct = 6'($urandom);
            endcase
            op_seq(op, s, n);
            abort_at = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            for (int i = 0; i < n; i++) begin
                zero = 1'($urandom);
                #1;
                st = s[4*i +: 4];
                chk("rand_state", 32'(state), 32'(st));
                chk("rand_ctrl", 32'(dut_ctrl), 32'(ref_ctrl(st, funct, zero)));
                if (i == abort_at) begin
                    reset = 1'b0; #1;
                    chk("rand_rst_comb", 32'(dut_ctrl), 32'(base[0]));
                    tick();
                    chk("rand_rst_state", 32'(state), 32'd0);
                    reset = 1'b1;
                    break;
                end
                tick();
            end
            $display("rand %0d op=%b funct=%b states=%0d abort=%0d", k, op, funct, n, abort_at);
        end
        chk("rand_end", 32'(state), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
